// File: rtl/player_cmd_scheduler.sv
// player_cmd_scheduler
// Latches front-panel button pulses as pending requests, serves them one at a
// time in fixed priority (play > next > prev > volup > voldn), owns the
// play/track/volume state and presents each change as a valid/ready command.
//
// state | meaning
// IDLE  | no command outstanding; picks the highest-priority pending request
// ISSUE | command held on cmd_code/cmd_arg until cmd_ready
module player_cmd_scheduler #(
  parameter int NUM_TRACKS = 10,
  parameter int TRACK_W    = 4,
  parameter int VOL_STEP   = 16,
  parameter int VOL_INIT   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_play,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_volup,
  input  logic               btn_voldn,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_code,
  output logic [7:0]         cmd_arg,
  output logic               playing,
  output logic [TRACK_W-1:0] track,
  output logic [7:0]         volume
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [1:0] CODE_PLAY   = 2'd0;
  localparam logic [1:0] CODE_PAUSE  = 2'd1;
  localparam logic [1:0] CODE_TRACK  = 2'd2;
  localparam logic [1:0] CODE_VOLUME = 2'd3;

  localparam int REQ_PLAY  = 0;
  localparam int REQ_NEXT  = 1;
  localparam int REQ_PREV  = 2;
  localparam int REQ_VOLUP = 3;
  localparam int REQ_VOLDN = 4;

  localparam logic [TRACK_W-1:0] TRACK_LAST = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [TRACK_W-1:0] TRACK_ONE  = TRACK_W'(1);
  localparam logic [7:0]         VOL_STEP_B = 8'(VOL_STEP);
  localparam logic [7:0]         VOL_UP_LIM = 8'(255 - VOL_STEP);
  localparam logic [7:0]         VOL_MAX    = 8'hFF;
  localparam logic [7:0]         VOL_RST    = 8'(VOL_INIT);

  state_t               state;
  logic [4:0]           pending;
  logic [4:0]           btn_vec;
  logic [4:0]           sel;
  logic [TRACK_W-1:0]   track_inc;
  logic [TRACK_W-1:0]   track_dec;
  logic [7:0]           vol_up;
  logic [7:0]           vol_dn;

  assign btn_vec = {btn_voldn, btn_volup, btn_prev, btn_next, btn_play};

  // One-hot pick of the highest-priority pending request, only while IDLE
  always_comb begin
    sel = '0;
    if (state == IDLE) begin
      if (pending[REQ_PLAY])       sel[REQ_PLAY]  = 1'b1;
      else if (pending[REQ_NEXT])  sel[REQ_NEXT]  = 1'b1;
      else if (pending[REQ_PREV])  sel[REQ_PREV]  = 1'b1;
      else if (pending[REQ_VOLUP]) sel[REQ_VOLUP] = 1'b1;
      else if (pending[REQ_VOLDN]) sel[REQ_VOLDN] = 1'b1;
    end
  end

  // Candidate new track/volume values with wrap and saturation applied
  always_comb begin
    track_inc = (track == TRACK_LAST) ? '0 : track + TRACK_ONE;
    track_dec = (track == '0) ? TRACK_LAST : track - TRACK_ONE;
    vol_up    = (volume > VOL_UP_LIM) ? VOL_MAX : volume + VOL_STEP_B;
    vol_dn    = (volume < VOL_STEP_B) ? 8'd0 : volume - VOL_STEP_B;
  end

  // Pending requests: a new pulse wins over the clear of the bit being served
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~sel) | btn_vec;
    end
  end

  // Scheduler FSM with registered command outputs and player state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_code  <= CODE_PLAY;
      cmd_arg   <= 8'd0;
      playing   <= 1'b0;
      track     <= '0;
      volume    <= VOL_RST;
    end else begin
      case (state)
        IDLE: begin
          if (sel[REQ_PLAY]) begin
            playing   <= ~playing;
            cmd_code  <= playing ? CODE_PAUSE : CODE_PLAY;
            cmd_arg   <= 8'd0;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (sel[REQ_NEXT]) begin
            track     <= track_inc;
            cmd_code  <= CODE_TRACK;
            cmd_arg   <= 8'(track_inc);
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (sel[REQ_PREV]) begin
            track     <= track_dec;
            cmd_code  <= CODE_TRACK;
            cmd_arg   <= 8'(track_dec);
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (sel[REQ_VOLUP]) begin
            // Already at full scale: request is consumed silently
            if (volume != VOL_MAX) begin
              volume    <= vol_up;
              cmd_code  <= CODE_VOLUME;
              cmd_arg   <= vol_up;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
          end else if (sel[REQ_VOLDN]) begin
            if (volume != 8'd0) begin
              volume    <= vol_dn;
              cmd_code  <= CODE_VOLUME;
              cmd_arg   <= vol_dn;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
